input_debounce_conditioner: RTL and testbench

Conditions raw asynchronous board inputs (push-buttons, slide switches) into clean, clock-synchronous levels for the 8-bit input PIO's `in_port`. Each bit gets a two-flop synchroniser, a per-bit debounce counter, and edge detection. Sticky rising-edge capture and an interrupt line let software poll or take an IRQ instead of sampling levels. Sits between the top-level pins and the PIO input port in the Qsys system wrapper.

---
 rtl/input_debounce_conditioner_pkg.sv | 15 +
 rtl/input_debounce_conditioner_debounce_bit.sv | 72 +++++++
 rtl/input_debounce_conditioner.sv | 65 ++++++
 tb/tb_input_debounce_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_conditioner_pkg.sv
// Shared constants and helpers for the input debounce conditioner.
//   DEFAULT_DEBOUNCE_CYCLES : 1 ms at 50 MHz
//   debounce_cnt_w()        : width of the per-bit debounce counter
package input_debounce_conditioner_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int MIN_DEBOUNCE_CYCLES     = 2;

  // The counter only has to reach DEBOUNCE_CYCLES-1. Clamping to 1 bit
  // avoids a zero-width counter for tiny test values.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < MIN_DEBOUNCE_CYCLES) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debounce_conditioner_debounce_bit.sv
// One conditioned input bit: two-flop synchroniser, debounce counter,
// stable level flop and registered edge pulses.
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   raw_i    : asynchronous pin input
//   stable_o : debounced level
//   rise_o   : one-cycle pulse in the first cycle stable_o reads 1
//   fall_o   : one-cycle pulse in the first cycle stable_o reads 0
module input_debounce_conditioner_debounce_bit
  import input_debounce_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  // Any sample agreeing with the current stable level restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES contrary samples is accepted.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise_d   = sync2_q;
      fall_d   = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule

// File: rtl/input_debounce_conditioner.sv
// Conditions raw board inputs into clean synchronous levels for the PIO
// in_port, with per-bit edge pulses, sticky rising-edge flags and an IRQ.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   raw_in       : asynchronous pin inputs
//   clear_edges  : write-one-to-clear strobe for edge_capture
//   stable_out   : debounced levels
//   rise_pulse   : one-cycle pulse per bit on stable 0->1
//   fall_pulse   : one-cycle pulse per bit on stable 1->0
//   edge_capture : sticky rising-edge flags
//   irq          : registered OR of edge_capture
module input_debounce_conditioner
  import input_debounce_conditioner_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = debounce_cnt_w(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clear_edges,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic             irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    input_debounce_conditioner_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce_bit (
      .clk_i    (clk),
      .rst_n_i  (reset_n),
      .raw_i    (raw_in[i]),
      .stable_o (stable_out[i]),
      .rise_o   (rise_pulse[i]),
      .fall_o   (fall_pulse[i])
    );
  end

  // Set is applied after clear so a rise coinciding with a clear is kept.
  always_comb begin
    edge_capture_d = (edge_capture_q & ~clear_edges) | rise_pulse;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture_q <= '0;
      irq_q          <= 1'b0;
    end else begin
      edge_capture_q <= edge_capture_d;
      irq_q          <= |edge_capture_d;
    end
  end

  assign edge_capture = edge_capture_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_input_debounce_conditioner.sv
module tb_input_debounce_conditioner;

  localparam int W = 8;
  localparam int DC = 4;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] clr;
    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] cap;
    logic       irq;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clear_edges = '0;
  logic [W-1:0] stable_out, rise_pulse, fall_pulse, edge_capture;
  logic         irq;

  int total = 0;
  int bad = 0;

  input_debounce_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .raw_in       (raw_in),
    .clear_edges  (clear_edges),
    .stable_out   (stable_out),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse),
    .edge_capture (edge_capture),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] st, input logic [7:0] ri,
                       input logic [7:0] fa, input logic [7:0] ca, input logic iq);
    total++;
    if ({stable_out, rise_pulse, fall_pulse, edge_capture, irq} !== {st, ri, fa, ca, iq}) begin
      bad++;
      $display("FAIL %s: got stable=%h rise=%h fall=%h cap=%h irq=%b, want stable=%h rise=%h fall=%h cap=%h irq=%b",
               name, stable_out, rise_pulse, fall_pulse, edge_capture, irq, st, ri, fa, ca, iq);
    end
  endtask

  task automatic do_reset(input logic [7:0] raw);
    reset_n = 1'b0;
    raw_in = raw;
    clear_edges = '0;
    #1;
    check("reset_async", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    check("reset_held", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b1;
  endtask

  vec_t tbl[22];
  logic bv[5];

  initial begin
    // Row i is driven before, and checked after, edge i+1 following reset release.
    for (int i = 0; i < 5; i++) tbl[i] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b1};
    tbl[7] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    for (int i = 8; i < 13; i++) tbl[i] = '{8'hFE, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[13] = '{8'hFE, 8'h00, 8'hFE, 8'h00, 8'h01, 8'h00, 1'b0};
    tbl[14] = '{8'hFE, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
    for (int i = 15; i < 20; i++) tbl[i] = '{8'hFF, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[20] = '{8'hFF, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0};
    tbl[21] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h01, 1'b1};

    // Inputs high through reset, then clean press/release on bit 0.
    do_reset(8'hFF);
    for (int i = 0; i < 22; i++) begin
      raw_in = tbl[i].raw;
      clear_edges = tbl[i].clr;
      tick();
      check($sformatf("table_row%0d", i), tbl[i].stable, tbl[i].rise, tbl[i].fall,
            tbl[i].cap, tbl[i].irq);
    end
    clear_edges = '0;

    // Bounce on bit 3: 1,0,1,1,0 then steady 1.
    do_reset(8'h00);
    bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int n = 1; n <= 10; n++) begin
      raw_in = (n <= 5) ? {4'b0, bv[n-1], 3'b0} : 8'h08;
      tick();
      check($sformatf("bounce_e%0d", n), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    check("bounce_rise", 8'h08, 8'h08, 8'h00, 8'h00, 1'b0);
    tick();
    check("bounce_cap", 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);

    // Rise on bit 1 coinciding with its clear; then clears drop irq.
    raw_in = 8'h0A;
    for (int n = 1; n <= 5; n++) begin
      tick();
      check($sformatf("b1_wait_e%0d", n), 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);
    end
    tick();
    check("b1_rise", 8'h0A, 8'h02, 8'h00, 8'h08, 1'b1);
    clear_edges = 8'h02;
    tick();
    check("set_beats_clear", 8'h0A, 8'h00, 8'h00, 8'h0A, 1'b1);
    clear_edges = 8'h08;
    tick();
    check("clear_b3", 8'h0A, 8'h00, 8'h00, 8'h02, 1'b1);
    clear_edges = 8'h02;
    tick();
    check("clear_b1_irq_low", 8'h0A, 8'h00, 8'h00, 8'h00, 1'b0);
    clear_edges = 8'h00;

    // Glitch of DEBOUNCE_CYCLES-1 on bit 5 is rejected.
    do_reset(8'h00);
    for (int n = 1; n <= 12; n++) begin
      raw_in = (n <= 3) ? 8'h20 : 8'h00;
      tick();
      check($sformatf("glitch3_e%0d", n), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    // A pulse of exactly DEBOUNCE_CYCLES is accepted, then released.
    for (int n = 1; n <= 5; n++) begin
      raw_in = (n <= 4) ? 8'h20 : 8'h00;
      tick();
      check($sformatf("pulse4_e%0d", n), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    check("pulse4_rise", 8'h20, 8'h20, 8'h00, 8'h00, 1'b0);
    tick();
    check("pulse4_cap", 8'h20, 8'h00, 8'h00, 8'h20, 1'b1);
    tick();
    tick();
    check("pulse4_hold", 8'h20, 8'h00, 8'h00, 8'h20, 1'b1);
    tick();
    check("pulse4_fall", 8'h00, 8'h00, 8'h20, 8'h20, 1'b1);
    tick();
    check("pulse4_after_fall", 8'h00, 8'h00, 8'h00, 8'h20, 1'b1);

    // Reset mid-count on bit 7 discards the partial count.
    do_reset(8'h00);
    raw_in = 8'h80;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check($sformatf("midcnt_e%0d", n), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    reset_n = 1'b0;
    #1;
    check("midcnt_reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    check("midcnt_reset_held", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    reset_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      check($sformatf("midcnt_restart_e%0d", n), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    end
    tick();
    check("midcnt_rise", 8'h80, 8'h80, 8'h00, 8'h00, 1'b0);
    tick();
    check("midcnt_cap", 8'h80, 8'h00, 8'h00, 8'h80, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
